// File: rtl/horner_pkg.sv
// -----------------------------------------------------------------------------
// horner_pkg
// Shared definitions for the Horner datapath (operativo_horner) and its serial
// multiplier (mult_serial).
//   - Operand A select codes (m0), operand B select codes (m1)
//   - RH source select codes (m2)
//   - Multiplier state encoding
// -----------------------------------------------------------------------------
package horner_pkg;

    // Operand A select (m0)
    localparam logic [1:0] SEL_A_RH   = 2'b00;
    localparam logic [1:0] SEL_A_RX   = 2'b01;
    localparam logic [1:0] SEL_A_C1   = 2'b10;
    localparam logic [1:0] SEL_A_C2   = 2'b11;

    // Operand B select (m1)
    localparam logic [1:0] SEL_B_RX   = 2'b00;
    localparam logic [1:0] SEL_B_RH   = 2'b01;
    localparam logic [1:0] SEL_B_C0   = 2'b10;
    localparam logic [1:0] SEL_B_ZERO = 2'b11;

    // RH source select (m2); AUTO picks P while a multiply is requested
    localparam logic [1:0] SEL_H_X    = 2'b00;
    localparam logic [1:0] SEL_H_SUM  = 2'b01;
    localparam logic [1:0] SEL_H_P    = 2'b10;
    localparam logic [1:0] SEL_H_AUTO = 2'b11;

    // Serial multiplier states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/operativo_horner_mult_serial.sv
// -----------------------------------------------------------------------------
// mult_serial
// Iterative shift-add multiplier, low W bits of a*b.
// Ports:
//   ck     in   clock
//   rst    in   synchronous active-low reset
//   start  in   multiply request (level, held by the controller)
//   a      in   multiplicand, captured when leaving IDLE
//   b      in   multiplier, captured when leaving IDLE
//   p      out  product register, held until the next completion
//   pronto out  1 while in DONE (registered Moore output)
// -----------------------------------------------------------------------------
module mult_serial
    import horner_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         pronto
);

    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mult_state_t   state_r;
    logic [W-1:0]  mcand_r;
    logic [W-1:0]  mplier_r;
    logic [W-1:0]  acc_r;
    logic [W-1:0]  p_r;
    logic [CW-1:0] cnt_r;
    logic          pronto_r;
    logic [W-1:0]  acc_next_s;
    logic          last_s;

    // Accumulator value after the current BUSY step (adds multiplicand on LSB=1)
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Final iteration flag: the W-th BUSY edge also writes P
    always_comb begin
        last_s = (cnt_r == LAST_CNT);
    end

    // Multiplier FSM, operand shifters, counter and product register
    always_ff @(posedge ck) begin
        if (!rst) begin
            state_r  <= IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            p_r      <= '0;
            cnt_r    <= '0;
            pronto_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[W-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        p_r      <= acc_next_s;
                        pronto_r <= 1'b1;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    // Only a low request releases DONE; a held request is ignored
                    if (!start) begin
                        pronto_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    pronto_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign p      = p_r;
    assign pronto = pronto_r;

endmodule

// File: rtl/operativo_horner.sv
// -----------------------------------------------------------------------------
// operativo_horner
// Horner-evaluation datapath: RX/RH/RS registers, operand muxes, wrapping
// adder and a serial multiplier, driven by an external control FSM.
// Ports:
//   ck, rst       clock, synchronous active-low reset
//   x_in          value loaded into RX (lx) or RH (m2=00)
//   c0, c1, c2    polynomial coefficients
//   lx, lh, ls    load strobes for RX, RH, RS
//   m0, m1, m2    operand A select, operand B select, RH source select
//   h             multiply request (level)
//   done          end-of-evaluation strobe from the controller
//   pronto        product valid
//   s_out         RS contents
//   valid         done delayed by one cycle
// -----------------------------------------------------------------------------
module operativo_horner
    import horner_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] c0,
    input  logic [W-1:0] c1,
    input  logic [W-1:0] c2,
    input  logic         lx,
    input  logic         lh,
    input  logic         ls,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    input  logic         h,
    input  logic         done,
    output logic         pronto,
    output logic [W-1:0] s_out,
    output logic         valid
);

    logic [W-1:0] rx_r;
    logic [W-1:0] rh_r;
    logic [W-1:0] rs_r;
    logic         valid_r;
    logic [W-1:0] op_a_s;
    logic [W-1:0] op_b_s;
    logic [W-1:0] sum_s;
    logic [W-1:0] rh_src_s;
    logic [W-1:0] p_s;
    logic         pronto_s;

    // Operand A multiplexer
    always_comb begin
        op_a_s = rh_r;
        case (m0)
            SEL_A_RH: op_a_s = rh_r;
            SEL_A_RX: op_a_s = rx_r;
            SEL_A_C1: op_a_s = c1;
            SEL_A_C2: op_a_s = c2;
            default:  op_a_s = rh_r;
        endcase
    end

    // Operand B multiplexer
    always_comb begin
        op_b_s = rx_r;
        case (m1)
            SEL_B_RX:   op_b_s = rx_r;
            SEL_B_RH:   op_b_s = rh_r;
            SEL_B_C0:   op_b_s = c0;
            SEL_B_ZERO: op_b_s = '0;
            default:    op_b_s = rx_r;
        endcase
    end

    // Adder; the carry out is intentionally dropped (mod 2^W)
    always_comb begin
        sum_s = op_a_s + op_b_s;
    end

    // RH source multiplexer; AUTO follows h, not pronto, so it may pick a stale P
    always_comb begin
        rh_src_s = x_in;
        case (m2)
            SEL_H_X:   rh_src_s = x_in;
            SEL_H_SUM: rh_src_s = sum_s;
            SEL_H_P:   rh_src_s = p_s;
            SEL_H_AUTO: begin
                if (h) begin
                    rh_src_s = p_s;
                end else begin
                    rh_src_s = sum_s;
                end
            end
            default:   rh_src_s = x_in;
        endcase
    end

    mult_serial #(
        .W  (W),
        .CW (CW)
    ) u_mult (
        .ck     (ck),
        .rst    (rst),
        .start  (h),
        .a      (op_a_s),
        .b      (op_b_s),
        .p      (p_s),
        .pronto (pronto_s)
    );

    // Datapath registers; coincident loads all see pre-edge values
    always_ff @(posedge ck) begin
        if (!rst) begin
            rx_r    <= '0;
            rh_r    <= '0;
            rs_r    <= '0;
            valid_r <= 1'b0;
        end else begin
            if (lx) begin
                rx_r <= x_in;
            end
            if (lh) begin
                rh_r <= rh_src_s;
            end
            if (ls) begin
                rs_r <= rh_r;
            end
            valid_r <= done;
        end
    end

    assign s_out  = rs_r;
    assign valid  = valid_r;
    assign pronto = pronto_s;

endmodule

// File: tb/tb_operativo_horner.sv
// -----------------------------------------------------------------------------
// tb_operativo_horner
// Directed testbench for operativo_horner (W=8). Inputs change 1 time unit
// after each rising edge; outputs are observed at the same point.
// -----------------------------------------------------------------------------
module tb_operativo_horner;

    logic       ck;
    logic       rst;
    logic [7:0] x_in;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic       lx;
    logic       lh;
    logic       ls;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       done;
    logic       pronto;
    logic [7:0] s_out;
    logic       valid;

    int checks = 0;
    int errors = 0;

    operativo_horner #(.W(8), .CW(4)) dut (
        .ck     (ck),
        .rst    (rst),
        .x_in   (x_in),
        .c0     (c0),
        .c1     (c1),
        .c2     (c2),
        .lx     (lx),
        .lh     (lh),
        .ls     (ls),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .h      (h),
        .done   (done),
        .pronto (pronto),
        .s_out  (s_out),
        .valid  (valid)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // RH <= selected source
    task automatic load_rh(input logic [1:0] a_sel, input logic [1:0] b_sel, input logic [1:0] h_sel);
        m0 = a_sel;
        m1 = b_sel;
        m2 = h_sel;
        lh = 1'b1;
        step();
        lh = 1'b0;
    endtask

    // Copy RH into RS so it is visible on s_out
    task automatic show_rh();
        ls = 1'b1;
        step();
        ls = 1'b0;
    endtask

    // Multiply with the current m0/m1, load the product into RH via h_sel, release h
    task automatic do_mul(input string tag, input logic [1:0] h_sel);
        h = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pronto) break;
            step();
        end
        chk({tag, "_pronto"}, 32'(pronto), 32'd1);
        m2 = h_sel;
        lh = 1'b1;
        step();
        lh = 1'b0;
        h  = 1'b0;
        step();
        chk({tag, "_pronto_low"}, 32'(pronto), 32'd0);
    endtask

    initial begin
        rst = 1'b0; x_in = 8'd55; c0 = 8'd0; c1 = 8'd0; c2 = 8'd0;
        lx = 1'b1; lh = 1'b1; ls = 1'b1; h = 1'b1; done = 1'b1;
        m0 = 2'b01; m1 = 2'b10; m2 = 2'b00;

        // Reset with every strobe active
        step();
        step();
        chk("rst_s_out", 32'(s_out), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);

        rst = 1'b1; lx = 1'b0; lh = 1'b0; ls = 1'b0; h = 1'b0; done = 1'b0;
        load_rh(2'b00, 2'b00, 2'b01);       // RH <= RH + RX
        show_rh();
        chk("rst_rh_rx_zero", 32'(s_out), 32'd0);
        chk("rst_valid_after", 32'(valid), 32'd0);

        // Load / add
        x_in = 8'd3; lx = 1'b1; step(); lx = 1'b0;
        c0 = 8'd5;
        load_rh(2'b01, 2'b10, 2'b01);       // RH <= RX + c0 = 8
        show_rh();
        chk("add_rx_c0", 32'(s_out), 32'd8);

        // Coincident lh+ls: RS gets old RH, RH <= RX+RX
        m0 = 2'b01; m1 = 2'b00; m2 = 2'b01; lh = 1'b1; ls = 1'b1;
        step();
        lh = 1'b0; ls = 1'b0;
        chk("coinc_rs_old_rh", 32'(s_out), 32'd8);
        show_rh();
        chk("coinc_rh_new", 32'(s_out), 32'd6);

        // Coincident lx+lh: RH gets the old RX
        x_in = 8'd10; lx = 1'b1;
        load_rh(2'b01, 2'b11, 2'b01);
        lx = 1'b0;
        show_rh();
        chk("coinc_rh_old_rx", 32'(s_out), 32'd3);

        // Multiply latency: RX=3, RH=7
        x_in = 8'd3; lx = 1'b1; step(); lx = 1'b0;
        x_in = 8'd7;
        load_rh(2'b00, 2'b00, 2'b00);
        m0 = 2'b00; m1 = 2'b00;
        h = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("lat_busy_%0d", i), 32'(pronto), 32'd0);
        end
        step();
        chk("lat_pronto_9", 32'(pronto), 32'd1);
        load_rh(2'b00, 2'b00, 2'b10);
        show_rh();
        chk("mul_7x3", 32'(s_out), 32'd21);
        chk("lat_hold_done", 32'(pronto), 32'd1);
        h = 1'b0;
        step();
        chk("lat_drop", 32'(pronto), 32'd0);

        // Wrapping sum and truncated products
        c1 = 8'd200; c0 = 8'd100;
        load_rh(2'b10, 2'b10, 2'b01);
        show_rh();
        chk("sum_wrap", 32'(s_out), 32'd44);

        c1 = 8'd20; c0 = 8'd20; m0 = 2'b10; m1 = 2'b10;
        do_mul("mul20", 2'b10);
        show_rh();
        chk("mul_20x20", 32'(s_out), 32'd144);

        c1 = 8'd16; c0 = 8'd17; m0 = 2'b10; m1 = 2'b10;
        do_mul("mul16", 2'b10);
        show_rh();
        chk("mul_16x17", 32'(s_out), 32'd16);

        // Full Horner run: (2*4+3)*4+1 = 45, AUTO source throughout
        c2 = 8'd2; c1 = 8'd3; c0 = 8'd1;
        x_in = 8'd4; lx = 1'b1; step(); lx = 1'b0;
        m0 = 2'b11; m1 = 2'b00;
        do_mul("hrn1", 2'b11);              // RH = c2*x = 8
        load_rh(2'b10, 2'b01, 2'b11);       // RH = c1 + RH = 11
        m0 = 2'b00; m1 = 2'b00;
        do_mul("hrn2", 2'b11);              // RH = RH*x = 44
        load_rh(2'b00, 2'b10, 2'b11);       // RH = RH + c0 = 45
        show_rh();
        chk("hrn_valid_before", 32'(valid), 32'd0);
        done = 1'b1; step(); done = 1'b0;
        chk("hrn_valid_pulse", 32'(valid), 32'd1);
        chk("hrn_result", 32'(s_out), 32'd45);
        step();
        chk("hrn_valid_end", 32'(valid), 32'd0);

        // Reset in the middle of BUSY aborts the multiply
        c1 = 8'd3; c0 = 8'd5; m0 = 2'b10; m1 = 2'b10;
        h = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0; h = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_pronto", 32'(pronto), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("abort_pronto_later", 32'(pronto), 32'd0);
        load_rh(2'b10, 2'b10, 2'b10);
        show_rh();
        chk("abort_p_zero", 32'(s_out), 32'd0);

        // Stale P: P=15 first, then read P during a 6*7 multiply
        do_mul("stale0", 2'b10);            // P = 15
        c1 = 8'd6; c0 = 8'd7;
        h = 1'b1;
        step();
        load_rh(2'b10, 2'b10, 2'b10);
        show_rh();
        chk("stale_p_m2_10", 32'(s_out), 32'd15);
        load_rh(2'b10, 2'b10, 2'b11);
        show_rh();
        chk("stale_p_auto", 32'(s_out), 32'd15);
        for (int i = 0; i < 20; i++) begin
            if (pronto) break;
            step();
        end
        chk("stale_pronto", 32'(pronto), 32'd1);
        load_rh(2'b10, 2'b10, 2'b10);
        show_rh();
        chk("mul_6x7", 32'(s_out), 32'd42);

        // Held h in DONE does not restart the multiplier
        c1 = 8'd2; c0 = 8'd3;
        for (int i = 0; i < 12; i++) step();
        chk("done_hold_pronto", 32'(pronto), 32'd1);
        load_rh(2'b10, 2'b10, 2'b10);
        show_rh();
        chk("done_hold_p", 32'(s_out), 32'd42);
        h = 1'b0;
        step();
        chk("done_release", 32'(pronto), 32'd0);
        do_mul("restart", 2'b10);
        show_rh();
        chk("mul_2x3", 32'(s_out), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
